sdram_arbiter: RTL and testbench

//  Command arbiter between SDRAM init, auto-refresh, write and read sub-controllers in uart_sdram_top.

---
 rtl/sdram_arbiter_if.sv | 62 ++++++
 rtl/sdram_arbiter.sv | 111 +++++++++++
 tb/tb_sdram_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/sdram_arbiter_if.sv
// SDRAM command-bus bundle between the sub-controllers, the arbiter and the pins.
// No flow control: request/grant levels plus one-cycle end pulses.
interface sdram_arbiter_if #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 16
);
   logic              init_end;
   logic [3:0]        init_cmd;
   logic [1:0]        init_ba;
   logic [ADDR_W-1:0] init_addr;
   logic              aref_req;
   logic              aref_end;
   logic [3:0]        aref_cmd;
   logic [1:0]        aref_ba;
   logic [ADDR_W-1:0] aref_addr;
   logic              wr_req;
   logic              wr_end;
   logic [3:0]        wr_cmd;
   logic [1:0]        wr_ba;
   logic [ADDR_W-1:0] wr_addr;
   logic              wr_dq_oe;
   logic [DATA_W-1:0] wr_dq;
   logic              rd_req;
   logic              rd_end;
   logic [3:0]        rd_cmd;
   logic [1:0]        rd_ba;
   logic [ADDR_W-1:0] rd_addr;
   logic              aref_en;
   logic              wr_en;
   logic              rd_en;
   logic              cke;
   logic              sdram_cs_n;
   logic              sdram_ras_n;
   logic              sdram_cas_n;
   logic              sdram_we_n;
   logic [1:0]        sdram_ba;
   logic [ADDR_W-1:0] sdram_addr;
   logic [DATA_W-1:0] sdram_dq_out;
   logic              sdram_dq_oe;

   // Arbiter side.
   modport slave (
      input  init_end, init_cmd, init_ba, init_addr,
      input  aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
      input  wr_req, wr_end, wr_cmd, wr_ba, wr_addr, wr_dq_oe, wr_dq,
      input  rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
      output aref_en, wr_en, rd_en, cke,
      output sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
      output sdram_ba, sdram_addr, sdram_dq_out, sdram_dq_oe
   );

   // Sub-controller / pin side.
   modport master (
      output init_end, init_cmd, init_ba, init_addr,
      output aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
      output wr_req, wr_end, wr_cmd, wr_ba, wr_addr, wr_dq_oe, wr_dq,
      output rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
      input  aref_en, wr_en, rd_en, cke,
      input  sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
      input  sdram_ba, sdram_addr, sdram_dq_out, sdram_dq_oe
   );
endinterface

// File: rtl/sdram_arbiter.sv
// SDRAM command arbiter: refresh beats write/read, write and read alternate.
// Latency: grant one edge after request seen in ARBIT; pins are a decode of state.
// Backpressure: requests wait as levels; grants are held until the owner's end pulse.
module sdram_arbiter #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 16
) (
   input  logic           clk,
   input  logic           rst,
   sdram_arbiter_if.slave bus
);

   typedef enum logic [2:0] {
      S_INIT  = 3'd0,
      S_ARBIT = 3'd1,
      S_AREF  = 3'd2,
      S_WRITE = 3'd3,
      S_READ  = 3'd4
   } state_t;

   state_t state, state_nxt;
   logic   last_wr;

   logic [3:0]        cmd;
   logic [1:0]        ba;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] dq_out;
   logic              dq_oe;
   logic              aref_en, wr_en, rd_en;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_INIT;
         last_wr <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == S_ARBIT && state_nxt == S_WRITE)
            last_wr <= 1'b1;
         else if (state == S_ARBIT && state_nxt == S_READ)
            last_wr <= 1'b0;
      end
   end

   always_comb begin
      state_nxt = state;
      cmd       = 4'b0111;
      ba        = 2'b11;
      addr      = {ADDR_W{1'b1}};
      dq_out    = {DATA_W{1'b0}};
      dq_oe     = 1'b0;
      aref_en   = 1'b0;
      wr_en     = 1'b0;
      rd_en     = 1'b0;
      case (state)
         S_INIT: begin
            cmd  = bus.init_cmd;
            ba   = bus.init_ba;
            addr = bus.init_addr;
            if (bus.init_end) state_nxt = S_ARBIT;
         end
         S_ARBIT: begin
            if (bus.aref_req)
               state_nxt = S_AREF;
            else if (bus.wr_req && bus.rd_req)
               state_nxt = last_wr ? S_READ : S_WRITE;
            else if (bus.wr_req)
               state_nxt = S_WRITE;
            else if (bus.rd_req)
               state_nxt = S_READ;
         end
         S_AREF: begin
            aref_en = 1'b1;
            cmd     = bus.aref_cmd;
            ba      = bus.aref_ba;
            addr    = bus.aref_addr;
            if (bus.aref_end) state_nxt = S_ARBIT;
         end
         S_WRITE: begin
            wr_en  = 1'b1;
            cmd    = bus.wr_cmd;
            ba     = bus.wr_ba;
            addr   = bus.wr_addr;
            dq_oe  = bus.wr_dq_oe;
            dq_out = bus.wr_dq;
            if (bus.wr_end) state_nxt = S_ARBIT;
         end
         S_READ: begin
            rd_en = 1'b1;
            cmd   = bus.rd_cmd;
            ba    = bus.rd_ba;
            addr  = bus.rd_addr;
            if (bus.rd_end) state_nxt = S_ARBIT;
         end
         default: state_nxt = S_INIT;
      endcase
   end

   assign bus.aref_en      = aref_en;
   assign bus.wr_en        = wr_en;
   assign bus.rd_en        = rd_en;
   assign bus.cke          = 1'b1;
   assign bus.sdram_cs_n   = cmd[3];
   assign bus.sdram_ras_n  = cmd[2];
   assign bus.sdram_cas_n  = cmd[1];
   assign bus.sdram_we_n   = cmd[0];
   assign bus.sdram_ba     = ba;
   assign bus.sdram_addr   = addr;
   assign bus.sdram_dq_out = dq_out;
   assign bus.sdram_dq_oe  = dq_oe;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: expected pin snapshots are queued per cycle
// by the stimulus and checked by an independent monitor on the falling edge.
module tb_sdram_arbiter;

   localparam int ADDR_W = 13;
   localparam int DATA_W = 16;

   typedef enum int {E_INIT, E_ARB, E_AREF, E_WR, E_RD} exp_state_t;

   typedef struct packed {
      logic              aref_en;
      logic              wr_en;
      logic              rd_en;
      logic              cke;
      logic [3:0]        cmd;
      logic [1:0]        ba;
      logic [ADDR_W-1:0] addr;
      logic              dq_oe;
      logic [DATA_W-1:0] dq_out;
   } snap_t;

   logic clk;
   logic rst;

   sdram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   sdram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   snap_t exp_q[$];
   string name_q[$];
   int    checks   = 0;
   int    failures = 0;
   int    step_no  = 0;

   // Hand-written expected pin image for each arbiter state, using the fixed
   // per-source command/bank/address values driven below.
   function automatic snap_t expect_for(exp_state_t s);
      snap_t e;
      e.cke    = 1'b1;
      e.aref_en = 1'b0;
      e.wr_en  = 1'b0;
      e.rd_en  = 1'b0;
      e.dq_oe  = 1'b0;
      e.dq_out = 16'h0000;
      case (s)
         E_INIT: begin e.cmd = 4'h1; e.ba = 2'd0; e.addr = 13'h0111; end
         E_ARB:  begin e.cmd = 4'h7; e.ba = 2'd3; e.addr = 13'h1FFF; end
         E_AREF: begin e.cmd = 4'h2; e.ba = 2'd1; e.addr = 13'h0222; e.aref_en = 1'b1; end
         E_WR:   begin e.cmd = 4'h3; e.ba = 2'd2; e.addr = 13'h0333; e.wr_en = 1'b1;
                       e.dq_oe = 1'b1; e.dq_out = 16'hA55A; end
         default: begin e.cmd = 4'h4; e.ba = 2'd3; e.addr = 13'h0444; e.rd_en = 1'b1; end
      endcase
      return e;
   endfunction

   // Drive one cycle of inputs, let one edge pass, then queue what the pins
   // must show during the following cycle.
   task automatic step(input logic r, input logic ie,
                       input logic aq, input logic ae,
                       input logic wq, input logic we,
                       input logic rq, input logic re,
                       input exp_state_t s, input string nm);
      rst          = r;
      bus.init_end = ie;
      bus.aref_req = aq;
      bus.aref_end = ae;
      bus.wr_req   = wq;
      bus.wr_end   = we;
      bus.rd_req   = rq;
      bus.rd_end   = re;
      @(posedge clk);
      #1;
      step_no++;
      exp_q.push_back(expect_for(s));
      name_q.push_back($sformatf("%s#%0d", nm, step_no));
   endtask

   // Monitor: every falling edge with something queued is a checked cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         snap_t e, a;
         string nm;
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         a.aref_en = bus.aref_en;
         a.wr_en   = bus.wr_en;
         a.rd_en   = bus.rd_en;
         a.cke     = bus.cke;
         a.cmd     = {bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n};
         a.ba      = bus.sdram_ba;
         a.addr    = bus.sdram_addr;
         a.dq_oe   = bus.sdram_dq_oe;
         a.dq_out  = bus.sdram_dq_out;
         checks++;
         if (a !== e) begin
            failures++;
            $display("FAIL %s: en(a/w/r)=%b%b%b cke=%b cmd=%h ba=%0d addr=%h oe=%b dq=%h ; need en=%b%b%b cke=%b cmd=%h ba=%0d addr=%h oe=%b dq=%h",
                     nm, a.aref_en, a.wr_en, a.rd_en, a.cke, a.cmd, a.ba, a.addr, a.dq_oe, a.dq_out,
                     e.aref_en, e.wr_en, e.rd_en, e.cke, e.cmd, e.ba, e.addr, e.dq_oe, e.dq_out);
         end
         checks++;
         if ($countones({bus.aref_en, bus.wr_en, bus.rd_en}) > 1) begin
            failures++;
            $display("FAIL grant_onehot %s: grants=%b, need at most one high",
                     nm, {bus.aref_en, bus.wr_en, bus.rd_en});
         end
      end
   end

   initial begin
      bus.init_cmd  = 4'h1; bus.init_ba = 2'd0; bus.init_addr = 13'h0111;
      bus.aref_cmd  = 4'h2; bus.aref_ba = 2'd1; bus.aref_addr = 13'h0222;
      bus.wr_cmd    = 4'h3; bus.wr_ba   = 2'd2; bus.wr_addr   = 13'h0333;
      bus.rd_cmd    = 4'h4; bus.rd_ba   = 2'd3; bus.rd_addr   = 13'h0444;
      bus.wr_dq_oe  = 1'b1; bus.wr_dq   = 16'hA55A;
      rst = 1'b1;
      bus.init_end = 1'b0;
      bus.aref_req = 1'b0; bus.aref_end = 1'b0;
      bus.wr_req   = 1'b0; bus.wr_end   = 1'b0;
      bus.rd_req   = 1'b0; bus.rd_end   = 1'b0;

      //     rst ie  aq ae  wq we  rq re   expected
      step(1, 0,  0, 0,  0, 0,  0, 0,  E_INIT, "reset");
      step(1, 1,  0, 0,  0, 0,  0, 0,  E_INIT, "reset_over_init_end");
      for (int i = 0; i < 8; i++)
         step(0, 0,  0, 0,  0, 0,  0, 0,  E_INIT, "wait_init");
      step(0, 1,  0, 0,  0, 0,  0, 0,  E_ARB,  "init_done");
      step(0, 1,  0, 0,  0, 0,  0, 1,  E_ARB,  "idle_stray_end");
      step(0, 1,  1, 0,  1, 0,  1, 0,  E_AREF, "aref_first");
      step(0, 1,  0, 0,  1, 0,  1, 0,  E_AREF, "aref_hold");
      step(0, 1,  0, 1,  1, 0,  1, 0,  E_ARB,  "aref_end_nop");
      step(0, 1,  0, 0,  1, 0,  1, 0,  E_WR,   "alt_w1");
      step(0, 1,  0, 0,  1, 0,  1, 1,  E_WR,   "w_ignores_rd_end");
      step(0, 1,  0, 0,  1, 1,  1, 0,  E_ARB,  "w1_end_nop");
      step(0, 1,  0, 0,  1, 0,  1, 0,  E_RD,   "alt_r1");
      step(0, 1,  0, 0,  1, 1,  1, 0,  E_RD,   "r_ignores_wr_end");
      step(0, 1,  0, 0,  1, 0,  1, 1,  E_ARB,  "r1_end_nop");
      step(0, 1,  0, 0,  1, 0,  1, 0,  E_WR,   "alt_w2");
      step(0, 1,  0, 0,  1, 1,  1, 0,  E_ARB,  "w2_end_nop");
      step(0, 1,  0, 0,  1, 0,  1, 0,  E_RD,   "alt_r2");
      step(1, 1,  0, 0,  1, 0,  1, 0,  E_INIT, "rst_mid_read");
      step(0, 0,  0, 0,  1, 0,  1, 0,  E_INIT, "rewait_init1");
      step(0, 0,  0, 0,  1, 0,  1, 0,  E_INIT, "rewait_init2");
      step(0, 1,  0, 0,  0, 0,  1, 0,  E_ARB,  "reinit_done");
      step(0, 1,  0, 0,  0, 0,  1, 0,  E_RD,   "rd_only");
      step(0, 1,  0, 0,  0, 0,  0, 1,  E_ARB,  "rd_only_end");
      step(0, 1,  0, 0,  1, 0,  0, 0,  E_WR,   "wr_only");
      step(0, 1,  1, 0,  1, 0,  0, 0,  E_WR,   "no_preempt");
      step(0, 1,  1, 0,  1, 1,  0, 0,  E_ARB,  "wr_end_aref_pending");
      step(0, 1,  1, 0,  1, 0,  0, 0,  E_AREF, "aref_beats_wr");
      step(0, 1,  0, 1,  1, 0,  0, 0,  E_ARB,  "aref_end_with_wr");
      step(0, 1,  0, 0,  1, 0,  0, 0,  E_WR,   "wr_after_aref");
      step(0, 1,  0, 0,  0, 1,  0, 0,  E_ARB,  "final_end");
      step(0, 1,  0, 0,  0, 0,  0, 0,  E_ARB,  "final_idle");

      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d expectations left unchecked, need 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
